// File: rtl/udp_payload_reader.sv
// udp_payload_reader
// Walks the payload of a received UDP packet in the shared Ethernet RAM and
// emits it as a byte stream (MSB of each word first) over valid/ready.
// The RAM port is read-only from here; `busy` lets the top level arbitrate it.

module udp_payload_reader #(
  parameter int                 ADDR_W     = 9,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(1),
  parameter int                 RD_LATENCY = 2,
  parameter int                 MAX_BYTES  = 2048
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       rx_data_length,
  input  logic              abort,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [31:0]       ram_rd_data,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              err_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_len;
  logic [15:0]        r_bytes_left;
  logic [2:0]         r_word_bytes;
  logic [1:0]         r_wait_cnt;
  logic [31:0]        r_shreg;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_valid;
  logic               r_err_flag;

  logic [15:0]        w_len_minus8;
  logic               w_len_bad;
  logic               w_hs;
  logic [2:0]         w_first_word_bytes;

  // Payload size is the UDP length minus the 8-byte header; anything shorter
  // than the header or larger than the RAM can hold is rejected.
  assign w_len_minus8 = r_len - 16'd8;
  assign w_len_bad    = (r_len < 16'd8) || (w_len_minus8 > 16'(MAX_BYTES));
  assign w_hs         = r_valid & m_ready;

  // Only the final word of a packet can carry fewer than four bytes.
  assign w_first_word_bytes = (r_bytes_left >= 16'd4) ? 3'd4 : r_bytes_left[2:0];

  assign ram_rd_addr = r_addr;
  assign m_data      = r_shreg[31:24];
  assign m_valid     = r_valid;
  assign m_last      = (r_state == S_SHIFT) && (r_bytes_left == 16'd1);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign err_len     = (r_state == S_DONE) && r_err_flag;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort overrides everything, including a start in IDLE.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start) w_state_nxt = S_CHECK;
        S_CHECK: begin
          if (w_len_bad || (w_len_minus8 == 16'd0)) w_state_nxt = S_DONE;
          else                                       w_state_nxt = S_FETCH;
        end
        S_FETCH: w_state_nxt = S_WAIT;
        S_WAIT:  if (r_wait_cnt == 2'd0) w_state_nxt = S_SHIFT;
        S_SHIFT: begin
          if (w_hs) begin
            if (r_bytes_left == 16'd1)      w_state_nxt = S_DONE;
            else if (r_word_bytes == 3'd1)  w_state_nxt = S_FETCH;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: length capture, RAM addressing, read-latency wait and byte shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_len        <= '0;
      r_bytes_left <= '0;
      r_word_bytes <= '0;
      r_wait_cnt   <= '0;
      r_shreg      <= '0;
      r_addr       <= BASE_ADDR;
      r_valid      <= 1'b0;
      r_err_flag   <= 1'b0;
    end else if (abort) begin
      r_valid    <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) r_len <= rx_data_length;
        end
        S_CHECK: begin
          r_bytes_left <= w_len_minus8;
          if (w_len_bad)                      r_err_flag <= 1'b1;
          else if (w_len_minus8 != 16'd0)     r_addr     <= BASE_ADDR;
        end
        S_FETCH: begin
          r_wait_cnt <= 2'(RD_LATENCY - 1);
        end
        S_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            r_shreg      <= ram_rd_data;
            r_word_bytes <= w_first_word_bytes;
            r_valid      <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        S_SHIFT: begin
          if (w_hs) begin
            r_shreg      <= {r_shreg[23:0], 8'h00};
            r_bytes_left <= r_bytes_left - 16'd1;
            r_word_bytes <= r_word_bytes - 3'd1;
            if (r_bytes_left == 16'd1) begin
              r_valid <= 1'b0;
            end else if (r_word_bytes == 3'd1) begin
              r_valid <= 1'b0;
              // Wraps naturally at 2^ADDR_W.
              r_addr  <= r_addr + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_payload_reader.sv
// Bench for udp_payload_reader: RAM model with 2-cycle read latency, a byte
// scoreboard fed from the RAM image, and one task per scenario.

module tb_udp_payload_reader;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        m_ready = 1'b0;
  logic        use_b = 1'b0;
  logic [15:0] rx_len = '0;
  logic        start_a, start_b;

  logic [8:0]  a_addr, b_addr;
  logic [31:0] a_rd_data, b_rd_data, a_d1, b_d1;
  logic [7:0]  a_data, b_data;
  logic        a_valid, b_valid, a_last, b_last, a_busy, b_busy;
  logic        a_done, b_done, a_err, b_err;

  logic [8:0]  w_addr;
  logic [7:0]  w_data;
  logic        w_valid, w_last, w_busy, w_done, w_err;

  logic [31:0] mem [512];

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] addr_log[$];

  int  n_checks = 0;
  int  n_errors = 0;
  int  hs_count = 0;
  int  valid_rises = 0;
  int  done_cnt = 0;
  int  cyc = 0;
  int  last_hs_cyc = -1;
  int  done_cyc = -1;
  bit  rand_ready = 1'b0;
  bit  ready_level = 1'b1;

  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  assign start_a = start & ~use_b;
  assign start_b = start & use_b;

  udp_payload_reader #(.ADDR_W(9), .BASE_ADDR(9'd1), .RD_LATENCY(RD_LAT), .MAX_BYTES(2048)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .rx_data_length(rx_len), .abort(abort),
    .ram_rd_addr(a_addr), .ram_rd_data(a_rd_data), .m_data(a_data), .m_valid(a_valid),
    .m_ready(m_ready), .m_last(a_last), .busy(a_busy), .done(a_done), .err_len(a_err)
  );

  udp_payload_reader #(.ADDR_W(9), .BASE_ADDR(9'd510), .RD_LATENCY(RD_LAT), .MAX_BYTES(2048)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .rx_data_length(rx_len), .abort(abort),
    .ram_rd_addr(b_addr), .ram_rd_data(b_rd_data), .m_data(b_data), .m_valid(b_valid),
    .m_ready(m_ready), .m_last(b_last), .busy(b_busy), .done(b_done), .err_len(b_err)
  );

  assign w_addr  = use_b ? b_addr  : a_addr;
  assign w_data  = use_b ? b_data  : a_data;
  assign w_valid = use_b ? b_valid : a_valid;
  assign w_last  = use_b ? b_last  : a_last;
  assign w_busy  = use_b ? b_busy  : a_busy;
  assign w_done  = use_b ? b_done  : a_done;
  assign w_err   = use_b ? b_err   : a_err;

  initial forever #4 clk = ~clk;

  // RAM model: data for a new address is valid two edges after the address changes.
  initial forever begin
    @(posedge clk);
    a_rd_data <= a_d1;
    a_d1      <= mem[a_addr];
    b_rd_data <= b_d1;
    b_d1      <= mem[b_addr];
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Downstream ready, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_level;
  end

  // Monitor: scoreboard pops, stall stability and word-fetch address log.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall && !abort) begin
        n_checks++;
        if (!(w_valid && w_data === prev_data && w_last === prev_last)) begin
          n_errors++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   w_valid, w_data, w_last, prev_data, prev_last);
        end
      end
      if (w_valid && !prev_valid) begin
        addr_log.push_back(w_addr);
        valid_rises++;
      end
      if (w_valid && m_ready) begin
        hs_count++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL byte_extra: got data=%h last=%b, required no byte", w_data, w_last);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (w_data !== e.data || w_last !== e.last) begin
            n_errors++;
            $display("FAIL byte: got data=%h last=%b, required data=%h last=%b",
                     w_data, w_last, e.data, e.last);
          end
        end
        if (w_last) last_hs_cyc = cyc;
      end
      if (w_err && !w_done) begin
        n_checks++;
        n_errors++;
        $display("FAIL err_without_done: err_len=1 done=0, required err_len only with done");
      end
      if (w_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = w_valid && !m_ready;
      prev_valid = w_valid;
      prev_data  = w_data;
      prev_last  = w_last;
    end
  end

  task automatic push_exp(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [8:0]  wa;
      logic [31:0] wd;
      exp_t        e;
      wa     = 9'((base + i / 4) % 512);
      wd     = mem[wa];
      e.data = wd[31 - 8 * (i % 4) -: 8];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_start(input logic [15:0] len, input logic sel_b);
    @(posedge clk);
    #1;
    use_b  = sel_b;
    rx_len = len;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output bit err);
    got = 1'b0;
    err = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      #1;
      if (w_done) begin
        got = 1'b1;
        err = w_err;
      end
    end
  endtask

  task automatic expect_done(input string name, input int budget, input bit err_exp);
    bit got, err;
    wait_done(budget, got, err);
    n_checks++;
    if (!got || err !== err_exp) begin
      n_errors++;
      $display("FAIL %s_done: got done=%b err_len=%b, required done=1 err_len=%b", name, got, err, err_exp);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d bytes missing, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_data, a_valid, a_last, a_busy, a_done, a_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: data=%h valid=%b last=%b busy=%b done=%b err=%b, required all 0",
               a_data, a_valid, a_last, a_busy, a_done, a_err);
    end
    n_checks++;
    if (a_addr !== 9'd1 || b_addr !== 9'd510) begin
      n_errors++;
      $display("FAIL reset_addr: a=%0d b=%0d, required a=1 b=510", a_addr, b_addr);
    end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    rand_ready  = 1'b0;
    ready_level = 1'b1;
    repeat (2) @(posedge clk);
    push_exp(1, 28);
    send_start(16'd36, 1'b0);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      lat++;
      if (w_valid) break;
    end
    n_checks++;
    if (lat != 3 + RD_LAT) begin
      n_errors++;
      $display("FAIL first_valid_latency: got %0d cycles, required %0d", lat, 3 + RD_LAT);
    end
    expect_done("basic", 200, 1'b0);
    n_checks++;
    if (done_cyc != last_hs_cyc + 1) begin
      n_errors++;
      $display("FAIL done_timing: done cycle %0d, required %0d", done_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic test_partial_word();
    addr_log.delete();
    push_exp(1, 5);
    send_start(16'd13, 1'b0);
    expect_done("partial", 100, 1'b0);
    n_checks++;
    if (addr_log.size() != 2 || addr_log[0] !== 9'd1 || addr_log[1] !== 9'd2) begin
      n_errors++;
      $display("FAIL partial_addrs: %0d words fetched (first %0d), required 2 words at 1,2",
               addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 9'd0);
    end
  endtask

  task automatic test_backpressure();
    rand_ready = 1'b1;
    push_exp(1, 28);
    send_start(16'd36, 1'b0);
    expect_done("backpressure", 1000, 1'b0);
    rand_ready = 1'b0;
  endtask

  task automatic test_lengths();
    logic [15:0] lens [4] = '{16'd8, 16'd5, 16'd2065, 16'd7};
    bit          errs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      int vr;
      vr = valid_rises;
      send_start(lens[i], 1'b0);
      expect_done($sformatf("len%0d", lens[i]), 20, errs[i]);
      n_checks++;
      if (valid_rises != vr) begin
        n_errors++;
        $display("FAIL len%0d_no_valid: m_valid rose %0d times, required 0", lens[i], valid_rises - vr);
      end
    end
    // Largest legal payload: every RAM word, wrapping from 511 back to 0.
    push_exp(1, 2048);
    send_start(16'd2056, 1'b0);
    expect_done("len_max", 6000, 1'b0);
  endtask

  task automatic test_addr_wrap();
    addr_log.delete();
    push_exp(510, 12);
    send_start(16'd20, 1'b1);
    expect_done("wrap", 100, 1'b0);
    n_checks++;
    if (addr_log.size() != 3 || addr_log[0] !== 9'd510 || addr_log[1] !== 9'd511 || addr_log[2] !== 9'd0) begin
      n_errors++;
      $display("FAIL wrap_addrs: %0d words fetched, required 3 at 510,511,0", addr_log.size());
    end
    @(negedge clk);
    use_b = 1'b0;
  endtask

  task automatic test_abort_restart();
    int hs0, dc;
    push_exp(1, 28);
    hs0 = hs_count;
    send_start(16'd36, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (hs_count - hs0 >= 6) break;
    end
    abort = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    abort = 1'b0;
    n_checks++;
    if (w_valid !== 1'b0 || w_busy !== 1'b0 || w_last !== 1'b0 || w_done !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_outputs: valid=%b busy=%b last=%b done=%b, required all 0",
               w_valid, w_busy, w_last, w_done);
    end
    n_checks++;
    if (hs_count - hs0 != 6) begin
      n_errors++;
      $display("FAIL abort_count: %0d bytes before abort, required 6", hs_count - hs0);
    end
    dc = done_cnt;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt != dc) begin
      n_errors++;
      $display("FAIL abort_no_done: %0d done pulses, required 0", done_cnt - dc);
    end
    // Restart; a second start while busy must be ignored.
    push_exp(1, 4);
    dc = done_cnt;
    send_start(16'd12, 1'b0);
    repeat (2) @(negedge clk);
    send_start(16'd36, 1'b0);
    expect_done("restart", 100, 1'b0);
    repeat (30) @(negedge clk);
    n_checks++;
    if (done_cnt - dc != 1 || w_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_while_busy: %0d done pulses busy=%b, required 1 pulse busy=0",
               done_cnt - dc, w_busy);
    end
    // Start together with abort in IDLE: abort wins.
    dc = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_cnt != dc || w_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_with_abort: %0d done pulses busy=%b, required 0 and busy=0",
               done_cnt - dc, w_busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    ready_level = 1'b0;
    push_exp(1, 28);
    send_start(16'd36, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = w_valid;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL reset_mid_valid: m_valid never rose, required 1");
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({a_data, a_valid, a_last, a_busy, a_done, a_err} !== '0 || a_addr !== 9'd1) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: data=%h valid=%b last=%b busy=%b addr=%0d, required 0s and addr=1",
               a_data, a_valid, a_last, a_busy, a_addr);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    reset_n     = 1'b1;
    ready_level = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      logic [8:0] k;
      k = 9'(i);
      mem[i] = {k[7:0], k[7:0] ^ 8'h5A, ~k[7:0], 8'(k * 3)};
    end
    mem[1] = 32'h48454C4C;
    mem[2] = 32'h4F20574F;
    mem[3] = 32'h524C440A;
    mem[4] = 32'h7777772E;
    mem[5] = 32'h68736564;
    mem[6] = 32'h612E636F;
    mem[7] = 32'h6D20200A;

    test_reset();
    test_basic();
    test_partial_word();
    test_backpressure();
    test_lengths();
    test_addr_wrap();
    test_abort_restart();
    test_reset_mid_shift();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
